dual_input_debouncer: RTL

Input-conditioning stage that sits directly upstream of the two-input AND gate. It takes two raw asynchronous switch/pushbutton levels, synchronises each into the clock domain, and debounces each one. It presents clean, stable levels on a_out/b_out, which drive the gate's a/b inputs, plus one-cycle edge pulses for downstream counters or LEDs.

---
 rtl/dual_input_debouncer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dual_input_debouncer.sv
// Two independent synchronise-and-debounce channels that condition raw switch levels
// for the downstream AND gate, with registered one-cycle rise/fall pulses.

// state      | meaning
// S_LOW      | stable level 0, waiting for a synchronised 1
// S_CHK_HIGH | level 0, counting consecutive 1 samples before committing high
// S_HIGH     | stable level 1, waiting for a synchronised 0
// S_CHK_LOW  | level 1, counting consecutive 0 samples before committing low
module debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  typedef enum logic [1:0] {S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Any sample disagreeing with the candidate level abandons the check with cnt cleared.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      S_LOW: begin
        if (s2) begin
          state_nxt = S_CHK_HIGH;
          cnt_nxt   = '0;
        end
      end
      S_CHK_HIGH: begin
        if (!s2) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s2) begin
          state_nxt = S_CHK_LOW;
          cnt_nxt   = '0;
        end
      end
      S_CHK_LOW: begin
        if (s2) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end
endmodule

module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);
  debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_chan_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (a_raw),
    .level (a_out),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_chan_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (b_raw),
    .level (b_out),
    .rise  (b_rise),
    .fall  (b_fall)
  );
endmodule
